// File: rtl/note_env_ctrl.sv
// Single-voice note decoder and tick-paced ADSR envelope feeding Amp.amp and sine_gen.freq_mod.
// Commands take priority over envelope steps; the last note-on retriggers ATTACK from the current level.
module note_env_ctrl #(
    parameter int unsigned TICK_DIV      = 48_000,
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 2,
    parameter int unsigned RELEASE_STEP  = 4,
    parameter int unsigned SUSTAIN_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_valid,
    output logic [9:0]  amp,
    output logic [9:0]  freq_mod,
    output logic [6:0]  note_out,
    output logic        active,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic       rsvd;
        logic [6:0] vel;
    } cmd_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    cmd_t          c;
    logic          unused_rsvd;
    logic [CW-1:0] cnt;
    logic          tick;
    state_t        st, st_nxt;
    logic [9:0]    amp_nxt, peak, peak_nxt, sustain;
    logic [6:0]    note_nxt;
    logic [10:0]   att_sum;
    logic signed [11:0] dec_dif, rel_dif;

    assign c           = cmd_t'(cmd);
    assign unused_rsvd = c.rsvd;
    assign tick        = (cnt == CW'(TICK_DIV - 1));
    assign sustain     = peak >> SUSTAIN_SHIFT;

    // Free-running step prescaler; commands never restart it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Widened arithmetic so overshoot/underflow is visible before clamping
    assign att_sum = {1'b0, amp} + 11'(ATTACK_STEP);
    assign dec_dif = signed'({2'b00, amp}) - signed'(12'(DECAY_STEP));
    assign rel_dif = signed'({2'b00, amp}) - signed'(12'(RELEASE_STEP));

    always_comb begin
        st_nxt   = st;
        amp_nxt  = amp;
        peak_nxt = peak;
        note_nxt = note_out;
        if (cmd_valid) begin
            if (c.on && (c.vel != 7'd0)) begin
                note_nxt = c.note;
                peak_nxt = {c.vel, c.vel[6:4]};
                st_nxt   = ATTACK;
            end else if ((c.note == note_out) &&
                         (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
                st_nxt = RELEASE;
            end
        end else if (tick) begin
            case (st)
                ATTACK: begin
                    if (att_sum >= {1'b0, peak}) begin
                        amp_nxt = peak;
                        st_nxt  = DECAY;
                    end else begin
                        amp_nxt = att_sum[9:0];
                    end
                end
                DECAY: begin
                    if (dec_dif <= signed'({2'b00, sustain})) begin
                        amp_nxt = sustain;
                        st_nxt  = SUSTAIN;
                    end else begin
                        amp_nxt = dec_dif[9:0];
                    end
                end
                RELEASE: begin
                    if (rel_dif <= 12'sd0) begin
                        amp_nxt = '0;
                        st_nxt  = IDLE;
                    end else begin
                        amp_nxt = rel_dif[9:0];
                    end
                end
                IDLE:    amp_nxt = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            amp      <= '0;
            peak     <= '0;
            note_out <= '0;
            freq_mod <= '0;
            active   <= 1'b0;
        end else begin
            st       <= st_nxt;
            amp      <= amp_nxt;
            peak     <= peak_nxt;
            note_out <= note_nxt;
            freq_mod <= {note_nxt, 3'b000};
            active   <= (st_nxt != IDLE);
        end
    end

    assign state = st;

endmodule
